leve_burst_fetch: RTL and testbench

Parametrised AXI read initiator that fetches a programmed number of fixed-length bursts from a linear address range and delivers the returned beats on a back-pressured output stream. Issue is limited by an outstanding-transaction limit and a reserved-space credit scheme on an internal beat FIFO. Response status and burst framing are also checked. It sits between a local consumer (core, DMA sink or test harness) and the AXI read channels of the LEVE interconnect.

---
 rtl/leve_burst_fetch_if.sv | 28 ++
 rtl/leve_burst_fetch.sv | 190 +++++++++++++++++++
 tb/tb_leve_burst_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leve_burst_fetch_if.sv
// AXI read address/data channel bundle used by leve_burst_fetch.
// master = read initiator side, slave = interconnect/memory side.
interface leve_burst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) ();
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/leve_burst_fetch.sv
// AXI read initiator: fetches num_bursts fixed-length bursts into a credit-reserved beat FIFO.
// Define LEVE_FETCH_RLAST_CHECK_EN to build the per-burst beat counter and RLAST framing check.
module leve_burst_fetch #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          BURST_LEN  = 4,
    parameter int          BEAT_BYTES = 16,
    parameter int          MAX_OUTST  = 4,
    parameter bit          WRAP_MODE  = 1'b1,
    parameter int          DATA_W     = BEAT_BYTES * 8
) (
    input  logic                clk,
    input  logic                rst,
    leve_burst_fetch_if.master  rii,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         num_bursts,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int DEPTH = MAX_OUTST * BURST_LEN;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = $clog2(MAX_OUTST + 1);

    localparam logic [31:0]   STRIDE   = 32'(BURST_LEN * BEAT_BYTES);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] BLEN_C   = CW'(BURST_LEN);
    localparam logic [OW-1:0] MAXO_C   = OW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [15:0]       remaining;
    logic [31:0]       addr;
    logic [OW-1:0]     outstanding;
    logic [CW-1:0]     reserved;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              ar_valid;
    logic              stop_req;
    logic [DATA_W-1:0] mem [DEPTH];

    logic          ar_hs;
    logic          r_hs;
    logic          pop;
    logic          burst_end;
    logic          frame_err;
    logic [15:0]   rem_n;
    logic [OW-1:0] out_n;
    logic [CW-1:0] resv_n;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] free_n;
    logic          can_issue;
    logic          issue_done;

    assign ar_hs      = ar_valid && rii.arready;
    assign r_hs       = rii.rvalid && rii.rready;
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;
    assign busy       = (state != IDLE);

    assign rii.arvalid = ar_valid;
    assign rii.araddr  = addr;
    assign rii.arlen   = 8'(BURST_LEN - 1);
    assign rii.arsize  = 3'($clog2(BEAT_BYTES));
    assign rii.arburst = WRAP_MODE ? 2'b10 : 2'b01;
    assign rii.rready  = (outstanding != '0);

`ifdef LEVE_FETCH_RLAST_CHECK_EN
    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    logic [BCW-1:0] beat_cnt;

    // Burst boundaries come from the beat count; RLAST is only cross-checked against it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (r_hs) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BCW'(1);
        end
    end

    assign burst_end = r_hs && (beat_cnt == LAST_BEAT);
    assign frame_err = r_hs && (rii.rlast != (beat_cnt == LAST_BEAT));
`else
    assign burst_end = r_hs && rii.rlast;
    assign frame_err = 1'b0;
`endif

    // Post-cycle counter values, so ARVALID can stay high back-to-back when credits allow.
    always_comb begin
        rem_n      = remaining - 16'(ar_hs);
        out_n      = outstanding + OW'(ar_hs) - OW'(burst_end);
        resv_n     = reserved + (ar_hs ? BLEN_C : '0) - CW'(r_hs);
        cnt_n      = count + CW'(r_hs) - CW'(pop);
        free_n     = DEPTH_C - cnt_n - resv_n;
        can_issue  = (rem_n != '0) && (out_n < MAXO_C) && (free_n >= BLEN_C);
        issue_done = (!ar_valid || ar_hs) && (stop || stop_req || (rem_n == '0));
    end

    always_ff @(posedge clk) begin
        if (r_hs) begin
            mem[wr_ptr] <= rii.rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            addr        <= BASE_ADDR;
            outstanding <= '0;
            reserved    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ar_valid    <= 1'b0;
            stop_req    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            outstanding <= out_n;
            reserved    <= resv_n;
            count       <= cnt_n;
            done        <= 1'b0;

            if (r_hs) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            if (r_hs && ((rii.rresp != 2'b00) || frame_err)) begin
                err <= 1'b1;
            end
            if (ar_hs) begin
                addr      <= addr + STRIDE;
                remaining <= rem_n;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        err       <= 1'b0;
                        remaining <= num_bursts;
                        addr      <= BASE_ADDR;
                        stop_req  <= 1'b0;
                        if (num_bursts == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            ar_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // A stop seen while ARVALID is pending is remembered until that handshake lands.
                    if (issue_done) begin
                        state    <= DRAIN;
                        ar_valid <= 1'b0;
                        stop_req <= 1'b0;
                    end else begin
                        ar_valid <= (ar_valid && !rii.arready) || can_issue;
                        if (stop) begin
                            stop_req <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((outstanding == '0) && (count == '0)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ar_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_leve_burst_fetch.sv
// Scoreboard testbench for leve_burst_fetch: directed runs against a zero-wait AXI memory model.
// A second instance with a base near 2^32 checks address wrap-around.
module tb_leve_burst_fetch;
    localparam int          BL     = 4;
    localparam int          BEAT_B = 16;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] BASE_W = 32'hFFFF_FFC0;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic [15:0]  num_bursts;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         done;
    logic         err;

    logic         start_w;
    logic [15:0]  num_w;
    logic [127:0] dout_w;
    logic         dout_valid_w;
    logic         busy_w;
    logic         done_w;
    logic         err_w;

    int compared   = 0;
    int mismatched = 0;
    int ar_seen    = 0;
    int done_cnt   = 0;
    int done_base  = 0;
    int ar_base    = 0;
    int beat_total = 0;
    int err_at     = -1;
    bit early_last = 1'b0;

    logic [31:0]  exp_addr [$];
    logic [127:0] exp_data [$];

    leve_burst_fetch_if #(.ADDR_W(32), .DATA_W(128)) mi ();
    leve_burst_fetch_if #(.ADDR_W(32), .DATA_W(128)) mw ();

    leve_burst_fetch #(
        .BASE_ADDR(BASE), .BURST_LEN(BL), .BEAT_BYTES(BEAT_B), .MAX_OUTST(4), .WRAP_MODE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .rii(mi.master), .start(start), .stop(stop),
        .num_bursts(num_bursts), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done), .err(err)
    );

    leve_burst_fetch #(
        .BASE_ADDR(BASE_W), .BURST_LEN(BL), .BEAT_BYTES(BEAT_B), .MAX_OUTST(4), .WRAP_MODE(1'b1)
    ) dut_w (
        .clk(clk), .rst(rst), .rii(mw.master), .start(start_w), .stop(1'b0),
        .num_bursts(num_w), .dout(dout_w), .dout_valid(dout_valid_w),
        .dout_ready(1'b1), .busy(busy_w), .done(done_w), .err(err_w)
    );

    assign mw.arready = 1'b1;
    assign mw.rvalid  = 1'b0;
    assign mw.rdata   = '0;
    assign mw.rresp   = 2'b00;
    assign mw.rlast   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] beatData(input logic [31:0] a);
        return {~a, a ^ 32'h5A5A_5A5A, a + 32'h1, a};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue the expected AR addresses and beats, then pulse START for one cycle.
    task automatic applyStimulus(input int n_start, input int n_expect, input logic [31:0] base);
        for (int i = 0; i < n_expect; i++) begin
            exp_addr.push_back(base + 32'(i * BL * BEAT_B));
            for (int j = 0; j < BL; j++) begin
                exp_data.push_back(beatData(base + 32'(i * BL * BEAT_B + j * BEAT_B)));
            end
        end
        @(negedge clk);
        beat_total = 0;
        done_base  = done_cnt;
        ar_base    = ar_seen;
        start      = 1'b1;
        num_bursts = 16'(n_start);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == done_base) checkOutput("done_timeout", 128'(0), 128'(1));
        @(negedge clk);
        #2;
    endtask

    task automatic checkReset();
        checkOutput("rst_arvalid", 128'(mi.arvalid), 128'(0));
        checkOutput("rst_araddr", 128'(mi.araddr), 128'(BASE));
        checkOutput("rst_rready", 128'(mi.rready), 128'(0));
        checkOutput("rst_dout_valid", 128'(dout_valid), 128'(0));
        checkOutput("rst_dout", dout, 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_done", 128'(done), 128'(0));
        checkOutput("rst_err", 128'(err), 128'(0));
    endtask

    // Zero-wait memory: drives on negedge, records handshakes that the next posedge will complete.
    initial begin
        logic [31:0] pend_q [$];
        logic [31:0] ar_cap;
        int  beat;
        bit  ar_f;
        bit  r_f;
        beat = 0; ar_f = 0; r_f = 0; ar_cap = '0;
        mi.arready = 1'b1; mi.rvalid = 1'b0; mi.rdata = '0; mi.rresp = 2'b00; mi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete(); beat = 0; ar_f = 0; r_f = 0; mi.rvalid = 1'b0;
            end else begin
                if (ar_f) pend_q.push_back(ar_cap);
                if (r_f) begin
                    beat_total++;
                    if (beat == BL - 1) begin
                        beat = 0;
                        void'(pend_q.pop_front());
                    end else begin
                        beat++;
                    end
                end
                if (pend_q.size() != 0) begin
                    mi.rvalid = 1'b1;
                    mi.rdata  = beatData(pend_q[0] + 32'(beat * BEAT_B));
                    mi.rlast  = (beat == BL - 1) || (early_last && beat == 1);
                    mi.rresp  = (beat_total == err_at) ? 2'b10 : 2'b00;
                end else begin
                    mi.rvalid = 1'b0; mi.rlast = 1'b0; mi.rresp = 2'b00;
                end
            end
            #1;
            if (rst) begin
                pend_q.delete(); beat = 0; ar_f = 0; r_f = 0; mi.rvalid = 1'b0;
            end else begin
                ar_f   = mi.arvalid && mi.arready;
                ar_cap = mi.araddr;
                r_f    = mi.rvalid && mi.rready;
            end
        end
    end

    // Monitor: compares every AR and every popped beat against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (mi.arvalid && mi.arready) begin
                    ar_seen++;
                    if (exp_addr.size() == 0) checkOutput("ar_unexpected", 128'(1), 128'(0));
                    else checkOutput("araddr", 128'(mi.araddr), 128'(exp_addr.pop_front()));
                    checkOutput("arlen", 128'(mi.arlen), 128'(BL - 1));
                    checkOutput("arburst", 128'(mi.arburst), 128'(2));
                end
                if (dout_valid && dout_ready) begin
                    if (exp_data.size() == 0) checkOutput("dout_unexpected", 128'(1), 128'(0));
                    else checkOutput("dout", dout, exp_data.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    checkOutput("done_busy", 128'(busy), 128'(0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] wrap_addr [4];
        int wrap_n;
        int n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; num_bursts = '0; dout_ready = 1'b1;
        start_w = 1'b0; num_w = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkReset();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic fetch");
        applyStimulus(3, 3, BASE);
        #2;
        checkOutput("arvalid_after_start", 128'(mi.arvalid), 128'(1));
        waitDone(200);
        checkOutput("basic_err", 128'(err), 128'(0));
        checkOutput("basic_ar_count", 128'(ar_seen - ar_base), 128'(3));
        checkOutput("basic_drained", 128'(exp_data.size()), 128'(0));

        $display("[TB] back-pressure");
        dout_ready = 1'b0;
        applyStimulus(6, 6, BASE);
        repeat (60) @(negedge clk);
        #2;
        checkOutput("bp_ar_count", 128'(ar_seen - ar_base), 128'(4));
        checkOutput("bp_arvalid", 128'(mi.arvalid), 128'(0));
        checkOutput("bp_dout_valid", 128'(dout_valid), 128'(1));
        @(negedge clk);
        dout_ready = 1'b1;
        waitDone(400);
        checkOutput("bp_ar_total", 128'(ar_seen - ar_base), 128'(6));
        checkOutput("bp_drained", 128'(exp_data.size()), 128'(0));

        $display("[TB] stop mid-run");
        applyStimulus(100, 5, BASE);
        n = 0;
        while (!((ar_seen - ar_base) == 4 && mi.arvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("stop_wait_timeout", 128'(0), 128'(1));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitDone(400);
        checkOutput("stop_ar_count", 128'(ar_seen - ar_base), 128'(5));
        checkOutput("stop_drained", 128'(exp_data.size()), 128'(0));
        checkOutput("stop_busy", 128'(busy), 128'(0));

        $display("[TB] zero bursts");
        applyStimulus(0, 0, BASE);
        #2;
        checkOutput("zero_done", 128'(done), 128'(1));
        checkOutput("zero_busy", 128'(busy), 128'(0));
        @(negedge clk);
        #2;
        checkOutput("zero_done_low", 128'(done), 128'(0));
        checkOutput("zero_no_ar", 128'(ar_seen - ar_base), 128'(0));

        $display("[TB] slave error");
        err_at = 5;
        applyStimulus(2, 2, BASE);
        waitDone(200);
        checkOutput("err_set", 128'(err), 128'(1));
        repeat (3) @(negedge clk);
        #2;
        checkOutput("err_sticky", 128'(err), 128'(1));
        err_at = -1;
        applyStimulus(1, 1, BASE);
        #2;
        checkOutput("err_clear", 128'(err), 128'(0));
        waitDone(200);
        checkOutput("err_drained", 128'(exp_data.size()), 128'(0));

`ifdef LEVE_FETCH_RLAST_CHECK_EN
        $display("[TB] early rlast");
        early_last = 1'b1;
        applyStimulus(1, 1, BASE);
        waitDone(200);
        checkOutput("rlast_err", 128'(err), 128'(1));
        early_last = 1'b0;
`endif

        $display("[TB] address wrap");
        wrap_n = 0;
        @(negedge clk);
        start_w = 1'b1;
        num_w   = 16'd2;
        @(negedge clk);
        start_w = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (mw.arvalid && wrap_n < 4) begin
                wrap_addr[wrap_n] = mw.araddr;
                wrap_n++;
            end
            @(negedge clk);
        end
        checkOutput("wrap_count", 128'(wrap_n), 128'(2));
        if (wrap_n >= 2) begin
            checkOutput("wrap_addr0", 128'(wrap_addr[0]), 128'(32'hFFFF_FFC0));
            checkOutput("wrap_addr1", 128'(wrap_addr[1]), 128'(32'h0000_0000));
        end
        checkOutput("wrap_busy", 128'(busy_w), 128'(1));
        checkOutput("wrap_err", 128'(err_w | done_w | dout_valid_w), 128'(0));

        $display("[TB] reset mid-burst");
        applyStimulus(2, 2, BASE);
        n = 0;
        while (!(beat_total == 1 && mi.rvalid) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 100) checkOutput("rst_wait_timeout", 128'(0), 128'(1));
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        #1;
        checkReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(2, 2, BASE);
        waitDone(200);
        checkOutput("post_rst_ar_count", 128'(ar_seen - ar_base), 128'(2));
        checkOutput("post_rst_drained", 128'(exp_data.size()), 128'(0));
        checkOutput("post_rst_err", 128'(err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
